friscv_axil_ram_ctrl: RTL and testbench

AXI4-lite slave front-end that drives one port of the byte-enable dual-port RAM. One instance sits directly upstream of each RAM port. It converts AXI4-lite write and read channels into registered RAM port commands: wren, wbe, word address and data. It handles one transaction at a time, arbitrates between reads and writes, and absorbs the RAM read latency (combinational or registered read).

---
 rtl/friscv_axil_pkg.sv | 23 ++
 rtl/friscv_axil_ram_arb.sv | 26 ++
 rtl/friscv_axil_ram_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_friscv_axil_ram_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/friscv_axil_pkg.sv
// Shared definitions for the AXI4-lite RAM front-end: response codes,
// controller state encoding and the byte-to-word address offset helper.
package friscv_axil_pkg;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_SLVERR = 2'b10;
  localparam logic [1:0] AXI_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD,
    RD_WAIT,
    RD_RESP
  } axil_state_e;

  // Number of byte-offset bits dropped to form a word address
  function automatic int unsigned word_offset(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/friscv_axil_ram_arb.sv
// Two-requester arbiter with alternating priority; the pointer flips on
// every granted transaction so contended traffic strictly alternates.
module friscv_axil_ram_arb (
  input  logic aclk,
  input  logic arst,
  input  logic wr_req,
  input  logic rd_req,
  input  logic take,
  output logic wr_gnt_c,
  output logic rd_gnt_c
);

  logic wr_prio;

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      wr_prio <= 1'b1;
    end else if (take) begin
      wr_prio <= ~wr_prio;
    end
  end

  assign wr_gnt_c = wr_req && (wr_prio || !rd_req);
  assign rd_gnt_c = rd_req && (!wr_prio || !wr_req);

endmodule

// File: rtl/friscv_axil_ram_ctrl.sv
// AXI4-lite slave driving one port of a byte-enable RAM, one transaction at a time.
// Define FRISCV_AXIL_RAM_DECERR_EN to reject out-of-range addresses with DECERR.
module friscv_axil_ram_ctrl
  import friscv_axil_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned AXI_ADDR_W = 16,
  parameter int unsigned RD_LATENCY = 0
) (
  input  logic                    aclk,
  input  logic                    arst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [AXI_ADDR_W-1:0]   awaddr,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [1:0]              bresp,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [AXI_ADDR_W-1:0]   araddr,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    ram_wren,
  output logic [DATA_WIDTH/8-1:0] ram_wbe,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  input  logic [DATA_WIDTH-1:0]   ram_rdata
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFF    = word_offset(DATA_WIDTH);
  localparam int unsigned HI     = ADDR_WIDTH + OFF;

  axil_state_e             state_q, state_d;
  logic                    err_q, err_d;
  logic                    awready_d, wready_d, arready_d;
  logic                    bvalid_d, rvalid_d, ram_wren_d;
  logic [1:0]              bresp_d, rresp_d;
  logic [DATA_WIDTH-1:0]   rdata_d, ram_wdata_d;
  logic [STRB_W-1:0]       ram_wbe_d;
  logic [ADDR_WIDTH-1:0]   ram_addr_d;
  logic                    take, rd_cap;
  logic                    wr_gnt_c, rd_gnt_c;
  logic                    aw_err_c, ar_err_c;
  logic [ADDR_WIDTH-1:0]   aw_word_c, ar_word_c;
  logic                    unused_addr;

  assign aw_word_c = awaddr[HI-1:OFF];
  assign ar_word_c = araddr[HI-1:OFF];

`ifdef FRISCV_AXIL_RAM_DECERR_EN
  assign aw_err_c = (awaddr >> HI) != '0;
  assign ar_err_c = (araddr >> HI) != '0;
`else
  assign aw_err_c = 1'b0;
  assign ar_err_c = 1'b0;
`endif

  // Byte-offset bits (and upper bits when aliasing) are intentionally dropped
  assign unused_addr = ^{awaddr, araddr};

  friscv_axil_ram_arb u_arb (
    .aclk     (aclk),
    .arst     (arst),
    .wr_req   (awvalid && wvalid),
    .rd_req   (arvalid),
    .take     (take),
    .wr_gnt_c (wr_gnt_c),
    .rd_gnt_c (rd_gnt_c)
  );

  // Next-state and next-output logic; readies are raised one cycle after the grant
  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    take        = 1'b0;
    rd_cap      = 1'b0;
    awready_d   = 1'b0;
    wready_d    = 1'b0;
    arready_d   = 1'b0;
    bvalid_d    = bvalid;
    bresp_d     = bresp;
    rvalid_d    = rvalid;
    rdata_d     = rdata;
    rresp_d     = rresp;
    ram_wren_d  = 1'b0;
    ram_wbe_d   = '0;
    ram_addr_d  = ram_addr;
    ram_wdata_d = ram_wdata;

    unique case (state_q)
      IDLE: begin
        if (awready && awvalid && wvalid) begin
          err_d       = aw_err_c;
          ram_addr_d  = aw_word_c;
          ram_wdata_d = wdata;
          ram_wren_d  = !aw_err_c;
          ram_wbe_d   = aw_err_c ? '0 : wstrb;
          state_d     = WR;
        end else if (arready && arvalid) begin
          err_d      = ar_err_c;
          ram_addr_d = ar_word_c;
          state_d    = RD;
        end else begin
          awready_d = wr_gnt_c;
          wready_d  = wr_gnt_c;
          arready_d = rd_gnt_c;
          take      = wr_gnt_c || rd_gnt_c;
        end
      end
      WR: begin
        bvalid_d = 1'b1;
        bresp_d  = err_q ? AXI_DECERR : AXI_OKAY;
        state_d  = WR_RESP;
      end
      WR_RESP: begin
        if (bready) begin
          bvalid_d = 1'b0;
          bresp_d  = AXI_OKAY;
          state_d  = IDLE;
        end
      end
      RD: begin
        if (RD_LATENCY == 0) begin
          rd_cap  = 1'b1;
          state_d = RD_RESP;
        end else begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        rd_cap  = 1'b1;
        state_d = RD_RESP;
      end
      RD_RESP: begin
        if (rready) begin
          rvalid_d = 1'b0;
          rresp_d  = AXI_OKAY;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rd_cap) begin
      rvalid_d = 1'b1;
      rdata_d  = err_q ? '0 : ram_rdata;
      rresp_d  = err_q ? AXI_DECERR : AXI_OKAY;
    end
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_q   <= IDLE;
      err_q     <= 1'b0;
      awready   <= 1'b0;
      wready    <= 1'b0;
      arready   <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= AXI_OKAY;
      rvalid    <= 1'b0;
      rdata     <= '0;
      rresp     <= AXI_OKAY;
      ram_wren  <= 1'b0;
      ram_wbe   <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      awready   <= awready_d;
      wready    <= wready_d;
      arready   <= arready_d;
      bvalid    <= bvalid_d;
      bresp     <= bresp_d;
      rvalid    <= rvalid_d;
      rdata     <= rdata_d;
      rresp     <= rresp_d;
      ram_wren  <= ram_wren_d;
      ram_wbe   <= ram_wbe_d;
      ram_addr  <= ram_addr_d;
      ram_wdata <= ram_wdata_d;
    end
  end

endmodule

// File: tb/tb_friscv_axil_ram_ctrl.sv
// Bench for friscv_axil_ram_ctrl: instance 0 uses a combinational-read RAM,
// instance 1 a registered-read RAM; responses are checked against a scoreboard.
module tb_friscv_axil_ram_ctrl;

  typedef struct {
    bit          is_rd;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  logic        aclk = 1'b0;
  logic        arst;
  logic        awvalid [2], awready [2], wvalid [2], wready [2];
  logic        bvalid [2], bready [2], arvalid [2], arready [2];
  logic        rvalid [2], rready [2], ram_wren [2];
  logic [15:0] awaddr [2], araddr [2];
  logic [31:0] wdata [2], rdata [2], ram_wdata [2];
  logic [3:0]  wstrb [2], ram_wbe [2];
  logic [1:0]  bresp [2], rresp [2];
  logic [7:0]  ram_addr [2];
  logic [31:0] ram_rdata0, ram_rdata1;
  logic [31:0] mem [2][256];
  logic [31:0] model [2][256];
  int          wren_cnt [2];
  exp_t        sb [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 aclk = ~aclk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    friscv_axil_ram_ctrl #(
      .ADDR_WIDTH(8), .DATA_WIDTH(32), .AXI_ADDR_W(16), .RD_LATENCY(g)
    ) u_dut (
      .aclk(aclk), .arst(arst),
      .awvalid(awvalid[g]), .awready(awready[g]), .awaddr(awaddr[g]),
      .wvalid(wvalid[g]), .wready(wready[g]), .wdata(wdata[g]), .wstrb(wstrb[g]),
      .bvalid(bvalid[g]), .bready(bready[g]), .bresp(bresp[g]),
      .arvalid(arvalid[g]), .arready(arready[g]), .araddr(araddr[g]),
      .rvalid(rvalid[g]), .rready(rready[g]), .rdata(rdata[g]), .rresp(rresp[g]),
      .ram_wren(ram_wren[g]), .ram_wbe(ram_wbe[g]), .ram_addr(ram_addr[g]),
      .ram_wdata(ram_wdata[g]), .ram_rdata((g == 0) ? ram_rdata0 : ram_rdata1)
    );
  end

  // Byte-enable RAMs: port 0 reads combinationally, port 1 through a register
  always @(posedge aclk) begin
    for (int d = 0; d < 2; d++) begin
      if (ram_wren[d]) begin
        for (int b = 0; b < 4; b++)
          if (ram_wbe[d][b]) mem[d][ram_addr[d]][8*b +: 8] <= ram_wdata[d][8*b +: 8];
        wren_cnt[d] <= wren_cnt[d] + 1;
      end
    end
    ram_rdata1 <= mem[1][ram_addr[1]];
  end
  assign ram_rdata0 = mem[0][ram_addr[0]];

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [85:0] outs(input int d);
    return {awready[d], wready[d], arready[d], bvalid[d], rvalid[d], ram_wren[d],
            ram_wbe[d], ram_addr[d], ram_wdata[d], rdata[d], bresp[d], rresp[d]};
  endfunction

  function automatic bit addr_err(input logic [15:0] addr);
    bit err;
    err = 1'b0;
`ifdef FRISCV_AXIL_RAM_DECERR_EN
    err = (addr[15:10] != 6'd0);
`endif
    return err;
  endfunction

  task automatic init_inputs();
    for (int d = 0; d < 2; d++) begin
      awvalid[d] = 0; wvalid[d] = 0; arvalid[d] = 0; bready[d] = 0; rready[d] = 0;
      awaddr[d] = '0; araddr[d] = '0; wdata[d] = '0; wstrb[d] = '0;
    end
  endtask

  task automatic do_write(input int d, input logic [15:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int stall);
    bit          err;
    logic [7:0]  w;
    exp_t        e;
    int          n;
    err = addr_err(addr);
    w   = addr[9:2];
    awaddr[d] = addr; wdata[d] = data; wstrb[d] = strb;
    awvalid[d] = 1; wvalid[d] = 1;
    e.is_rd = 0; e.resp = err ? 2'b11 : 2'b00; e.data = '0;
    sb.push_back(e);
    n = 0;
    while (!(awready[d] && wready[d]) && n < 50) begin tick(); n++; end
    n_tests++;
    if (n >= 50) begin
      n_fail++;
      $display("FAIL wr_handshake dut%0d: awready never rose within %0d cycles", d, n);
      awvalid[d] = 0; wvalid[d] = 0; sb.delete();
      return;
    end
    tick();
    awvalid[d] = 0; wvalid[d] = 0;
    n_tests++;
    if (err) begin
      if (ram_wren[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL wr_reject dut%0d: ram_wren=%b required 0", d, ram_wren[d]);
      end
    end else if ({ram_wren[d], ram_wbe[d], ram_addr[d], ram_wdata[d]} !== {1'b1, strb, w, data}) begin
      n_fail++;
      $display("FAIL wr_cmd dut%0d: wren=%b wbe=%h addr=%h wdata=%h required 1 %h %h %h",
               d, ram_wren[d], ram_wbe[d], ram_addr[d], ram_wdata[d], strb, w, data);
    end
    if (!err)
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[d][w][8*b +: 8] = data[8*b +: 8];
    tick();
    n_tests++;
    if (ram_wren[d] !== 1'b0 || bvalid[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_bvalid dut%0d: wren=%b bvalid=%b required 0 1", d, ram_wren[d], bvalid[d]);
    end
    e = sb.pop_front();
    n_tests++;
    if (e.is_rd || bresp[d] !== e.resp) begin
      n_fail++;
      $display("FAIL wr_bresp dut%0d: bresp=%b required %b", d, bresp[d], e.resp);
    end
    for (int i = 0; i < stall; i++) begin
      tick();
      n_tests++;
      if (bvalid[d] !== 1'b1 || bresp[d] !== e.resp || awready[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL wr_stall dut%0d: bvalid=%b bresp=%b awready=%b required 1 %b 0",
                 d, bvalid[d], bresp[d], awready[d], e.resp);
      end
    end
    bready[d] = 1;
    tick();
    bready[d] = 0;
    n_tests++;
    if (bvalid[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_bdone dut%0d: bvalid=%b required 0", d, bvalid[d]);
    end
  endtask

  task automatic do_read(input int d, input logic [15:0] addr, input int stall);
    bit         err;
    logic [7:0] w;
    exp_t       e;
    int         n, lat;
    err = addr_err(addr);
    w   = addr[9:2];
    araddr[d] = addr; arvalid[d] = 1;
    e.is_rd = 1; e.resp = err ? 2'b11 : 2'b00; e.data = err ? 32'h0 : model[d][w];
    sb.push_back(e);
    n = 0;
    while (!arready[d] && n < 50) begin tick(); n++; end
    n_tests++;
    if (n >= 50) begin
      n_fail++;
      $display("FAIL rd_handshake dut%0d: arready never rose within %0d cycles", d, n);
      arvalid[d] = 0; sb.delete();
      return;
    end
    tick();
    arvalid[d] = 0;
    n_tests++;
    if (ram_wren[d] !== 1'b0 || (!err && ram_addr[d] !== w)) begin
      n_fail++;
      $display("FAIL rd_addr dut%0d: wren=%b addr=%h required 0 %h", d, ram_wren[d], ram_addr[d], w);
    end
    lat = 1;
    while (!rvalid[d] && lat < 20) begin tick(); lat++; end
    n_tests++;
    if (lat != ((d == 0) ? 2 : 3)) begin
      n_fail++;
      $display("FAIL rd_latency dut%0d: rvalid after %0d cycles required %0d", d, lat, (d == 0) ? 2 : 3);
    end
    e = sb.pop_front();
    n_tests++;
    if (!e.is_rd || rdata[d] !== e.data || rresp[d] !== e.resp) begin
      n_fail++;
      $display("FAIL rd_data dut%0d: rdata=%h rresp=%b required %h %b", d, rdata[d], rresp[d], e.data, e.resp);
    end
    for (int i = 0; i < stall; i++) begin
      tick();
      n_tests++;
      if (rvalid[d] !== 1'b1 || rdata[d] !== e.data || rresp[d] !== e.resp || arready[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL rd_stall dut%0d: rvalid=%b rdata=%h arready=%b required 1 %h 0",
                 d, rvalid[d], rdata[d], arready[d], e.data);
      end
    end
    rready[d] = 1;
    tick();
    rready[d] = 0;
    n_tests++;
    if (rvalid[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_rdone dut%0d: rvalid=%b required 0", d, rvalid[d]);
    end
  endtask

  task automatic test_reset();
    init_inputs();
    arst = 1;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (outs(d) !== '0) begin
        n_fail++;
        $display("FAIL reset_values dut%0d: outputs=%h required 0", d, outs(d));
      end
    end
    tick(); tick();
    arst = 0;
    tick();
  endtask

  task automatic test_write_read();
    do_write(0, 16'h0010, 32'hDEAD_BEEF, 4'hF, 0);
    do_read(0, 16'h0010, 0);
  endtask

  task automatic test_partial_write();
    do_write(0, 16'h0010, 32'h0000_AA00, 4'b0010, 2);
    do_read(0, 16'h0010, 1);
    do_write(0, 16'h0010, 32'hFFFF_FFFF, 4'b0000, 0);
    do_read(0, 16'h0010, 0);
  endtask

  task automatic test_rd_latency1();
    do_write(1, 16'h0010, 32'hDEAD_BEEF, 4'hF, 0);
    do_read(1, 16'h0010, 5);
    do_write(1, 16'h03FC, 32'h0BAD_F00D, 4'hF, 3);
    do_read(1, 16'h03FC, 0);
  endtask

  task automatic test_back_to_back();
    int         grants, cyc;
    bit         order [4];
    logic [31:0] wd;
    exp_t       e;
    bit         hs_w, hs_r;
    init_inputs();
    arst = 1;
    awvalid[0] = 1; wvalid[0] = 1; arvalid[0] = 1;
    awaddr[0] = 16'h0020; araddr[0] = 16'h0020; wstrb[0] = 4'hF;
    wd = 32'hA000_0001; wdata[0] = wd;
    bready[0] = 1; rready[0] = 1;
    tick(); tick();
    arst = 0;
    grants = 0; cyc = 0;
    while (cyc < 200 && (grants < 4 || sb.size() != 0)) begin
      hs_w = awvalid[0] && awready[0] && wready[0];
      hs_r = arvalid[0] && arready[0];
      if (bvalid[0] || rvalid[0]) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_unexpected_resp: bvalid=%b rvalid=%b with nothing outstanding", bvalid[0], rvalid[0]);
        end else begin
          e = sb.pop_front();
          if (bvalid[0] && (e.is_rd || bresp[0] !== e.resp)) begin
            n_fail++;
            $display("FAIL b2b_bresp: got write resp %b required %s resp %b", bresp[0], e.is_rd ? "read" : "write", e.resp);
          end else if (rvalid[0] && (!e.is_rd || rdata[0] !== e.data || rresp[0] !== e.resp)) begin
            n_fail++;
            $display("FAIL b2b_rdata: rdata=%h rresp=%b required %h %b", rdata[0], rresp[0], e.data, e.resp);
          end
        end
      end
      if (hs_w && grants < 4) begin
        order[grants] = 0; grants++;
        model[0][8] = wd;
        e.is_rd = 0; e.resp = 2'b00; e.data = '0;
        sb.push_back(e);
      end
      if (hs_r && grants < 4) begin
        order[grants] = 1; grants++;
        e.is_rd = 1; e.resp = 2'b00; e.data = model[0][8];
        sb.push_back(e);
      end
      tick();
      cyc++;
      if (hs_w) begin wd = wd + 1; wdata[0] = wd; end
      if (grants >= 4) begin awvalid[0] = 0; wvalid[0] = 0; arvalid[0] = 0; end
    end
    init_inputs();
    n_tests++;
    if (grants != 4 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_complete: grants=%0d pending=%0d required 4 0", grants, sb.size());
      sb.delete();
    end
    for (int i = 0; i < 4; i++) begin
      bit exp_o;
      exp_o = ((i % 2) == 1);
      n_tests++;
      if (order[i] !== exp_o) begin
        n_fail++;
        $display("FAIL b2b_order[%0d]: grant=%s required %s", i, order[i] ? "R" : "W", exp_o ? "R" : "W");
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int n, cnt;
    do_write(0, 16'h000C, 32'h1111_1111, 4'hF, 0);
    cnt = wren_cnt[0];
    awaddr[0] = 16'h000C; wdata[0] = 32'h2222_2222; wstrb[0] = 4'hF;
    awvalid[0] = 1; wvalid[0] = 1;
    n = 0;
    while (!(awready[0] && wready[0]) && n < 50) begin tick(); n++; end
    tick();
    arst = 1;
    awvalid[0] = 0; wvalid[0] = 0;
    #1;
    n_tests++;
    if (outs(0) !== '0) begin
      n_fail++;
      $display("FAIL rst_async: outputs=%h required 0", outs(0));
    end
    tick(); tick(); tick();
    n_tests++;
    if (bvalid[0] !== 1'b0 || wren_cnt[0] !== cnt) begin
      n_fail++;
      $display("FAIL rst_drop: bvalid=%b wren_pulses=%0d required 0 %0d", bvalid[0], wren_cnt[0], cnt);
    end
    arst = 0;
    tick(); tick();
    n_tests++;
    if (bvalid[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_no_resp: bvalid=%b required 0", bvalid[0]);
    end
    do_read(0, 16'h000C, 0);
  endtask

  task automatic test_decerr();
    do_write(0, 16'h0400, 32'h1234_5678, 4'hF, 0);
    do_read(0, 16'h0400, 1);
    do_read(0, 16'h0000, 0);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial_write();
    test_rd_latency1();
    test_back_to_back();
    test_reset_mid_write();
    test_decerr();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
